// File: rtl/rp_trig_pkg.sv
// Shared constants for the trigger arming block: FSM state codes and the
// source-code map, whose upper entries move with the channel count.
package rp_trig_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int SRC_OFF     = 0;
  localparam int SRC_SW      = 1;
  localparam int SRC_CH_BASE = 2;

  // Channel k occupies codes SRC_CH_BASE+2k (rising) and +1 (falling).
  function automatic int src_ext_p(input int nch);
    return SRC_CH_BASE + 2*nch;
  endfunction

  function automatic int src_ext_n(input int nch);
    return SRC_CH_BASE + 2*nch + 1;
  endfunction

  function automatic int src_asg_p(input int nch);
    return SRC_CH_BASE + 2*nch + 2;
  endfunction

  function automatic int src_asg_n(input int nch);
    return SRC_CH_BASE + 2*nch + 3;
  endfunction

  function automatic int src_num(input int nch);
    return SRC_CH_BASE + 2*nch + 4;
  endfunction

endpackage

// File: rtl/rp_trig_arm_if.sv
// Bundle of raw trigger inputs travelling from the arming block to the mux.
interface rp_trig_arm_if #(
  parameter int NCH = 4
);
  logic           sw;
  logic [NCH-1:0] ch_p;
  logic [NCH-1:0] ch_n;
  logic           ext_p;
  logic           ext_n;
  logic           asg_p;
  logic           asg_n;

  modport master (output sw, ch_p, ch_n, ext_p, ext_n, asg_p, asg_n);
  modport slave  (input  sw, ch_p, ch_n, ext_p, ext_n, asg_p, asg_n);
endinterface

// File: rtl/rp_trig_mux.sv
// Combinational trigger source select: flattens every input into one vector
// ordered by source code, then picks the coded bit (unused codes give 0).
module rp_trig_mux
  import rp_trig_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int SRC_W = $clog2(6+2*NCH)
) (
  rp_trig_arm_if.slave    trg,
  input  logic [SRC_W-1:0] src,
  output logic             sel
);

  localparam int NSRC  = src_num(NCH);
  localparam int EXT_P = src_ext_p(NCH);
  localparam int EXT_N = src_ext_n(NCH);
  localparam int ASG_P = src_asg_p(NCH);
  localparam int ASG_N = src_asg_n(NCH);

  logic [NSRC-1:0] vec;

  always_comb begin
    vec          = '0;
    vec[SRC_SW]  = trg.sw;
    for (int k = 0; k < NCH; k++) begin
      vec[SRC_CH_BASE+2*k]   = trg.ch_p[k];
      vec[SRC_CH_BASE+2*k+1] = trg.ch_n[k];
    end
    vec[EXT_P]   = trg.ext_p;
    vec[EXT_N]   = trg.ext_n;
    vec[ASG_P]   = trg.asg_p;
    vec[ASG_N]   = trg.asg_n;
  end

  // Code 0 maps to vec[0], which is tied low, so "off" needs no special case.
  always_comb begin
    sel = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (src == SRC_W'(i)) sel = vec[i];
  end

endmodule

// File: rtl/rp_trig_arm.sv
// Trigger arming FSM: selects one trigger source, emits a registered one-cycle
// trig_o, and handles single/continuous modes with a holdoff between triggers.
module rp_trig_arm
  import rp_trig_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int HOLD_W = 32,
  parameter int SRC_W  = $clog2(6+2*NCH)
) (
  input  logic              adc_clk_i,
  input  logic              adc_rstn_i,
  input  logic [SRC_W-1:0]  cfg_src_i,
  input  logic              cfg_new_i,
  input  logic              cfg_mode_i,
  input  logic [HOLD_W-1:0] cfg_holdoff_i,
  input  logic              rst_do_i,
  input  logic              dly_do_i,
  input  logic              trig_dis_clr_i,
  input  logic              sw_trig_i,
  input  logic [NCH-1:0]    ch_trig_p_i,
  input  logic [NCH-1:0]    ch_trig_n_i,
  input  logic              ext_trig_p_i,
  input  logic              ext_trig_n_i,
  input  logic              asg_trig_p_i,
  input  logic              asg_trig_n_i,
  output logic              trig_o,
  output logic [1:0]        state_o,
  output logic [SRC_W-1:0]  src_o,
  output logic [31:0]       trig_cnt_o
);

  rp_trig_arm_if #(.NCH(NCH)) trg ();

  assign trg.sw    = sw_trig_i;
  assign trg.ch_p  = ch_trig_p_i;
  assign trg.ch_n  = ch_trig_n_i;
  assign trg.ext_p = ext_trig_p_i;
  assign trg.ext_n = ext_trig_n_i;
  assign trg.asg_p = asg_trig_p_i;
  assign trg.asg_n = asg_trig_n_i;

  logic              sel;
  logic [HOLD_W-1:0] hold;

  rp_trig_mux #(.NCH(NCH), .SRC_W(SRC_W)) u_mux (
    .trg (trg),
    .src (src_o),
    .sel (sel)
  );

  // Branch order encodes event priority: abort, re-arm, delay-done, trigger,
  // clear-disable. A trigger coincident with re-arm is dropped on purpose.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_o    <= ST_IDLE;
      src_o      <= '0;
      hold       <= '0;
      trig_cnt_o <= '0;
      trig_o     <= 1'b0;
    end else begin
      trig_o <= 1'b0;
      if (rst_do_i) begin
        state_o <= ST_IDLE;
        src_o   <= '0;
        hold    <= '0;
      end else if (cfg_new_i) begin
        src_o      <= cfg_src_i;
        trig_cnt_o <= '0;
        state_o    <= (cfg_src_i == '0) ? ST_IDLE : ST_ARMED;
      end else begin
        case (state_o)
          ST_ARMED: begin
            if (dly_do_i) begin
              state_o <= ST_IDLE;
              src_o   <= '0;
            end else if (sel) begin
              trig_o <= 1'b1;
              if (~&trig_cnt_o) trig_cnt_o <= trig_cnt_o + 32'd1;
              if (!cfg_mode_i) begin
                state_o <= ST_DONE;
                src_o   <= '0;
              end else if (cfg_holdoff_i != '0) begin
                state_o <= ST_HOLDOFF;
                hold    <= cfg_holdoff_i - HOLD_W'(1);
              end
            end
          end
          ST_HOLDOFF: begin
            if (dly_do_i) begin
              state_o <= ST_IDLE;
              src_o   <= '0;
            end else if (hold == '0) begin
              state_o <= ST_ARMED;
            end else begin
              hold <= hold - HOLD_W'(1);
            end
          end
          ST_DONE: begin
            if (trig_dis_clr_i) state_o <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rp_trig_arm.sv
// Bench for rp_trig_arm: directed scenarios with fixed expectations, then a
// randomized run against a timestamp-based reference model.
module tb_rp_trig_arm;

  localparam int NCH    = 4;
  localparam int HOLD_W = 32;
  localparam int SRC_W  = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [SRC_W-1:0]  cfg_src;
  logic              cfg_new, cfg_mode;
  logic [HOLD_W-1:0] cfg_holdoff;
  logic              rst_do, dly_do, trig_dis_clr;
  logic              trig;
  logic [1:0]        state;
  logic [SRC_W-1:0]  src;
  logic [31:0]       cnt;
  logic [38:0]       obs;

  int total = 0;
  int bad   = 0;

  rp_trig_arm_if #(.NCH(NCH)) bus ();

  rp_trig_arm #(.NCH(NCH), .HOLD_W(HOLD_W), .SRC_W(SRC_W)) dut (
    .adc_clk_i      (clk),
    .adc_rstn_i     (rstn),
    .cfg_src_i      (cfg_src),
    .cfg_new_i      (cfg_new),
    .cfg_mode_i     (cfg_mode),
    .cfg_holdoff_i  (cfg_holdoff),
    .rst_do_i       (rst_do),
    .dly_do_i       (dly_do),
    .trig_dis_clr_i (trig_dis_clr),
    .sw_trig_i      (bus.sw),
    .ch_trig_p_i    (bus.ch_p),
    .ch_trig_n_i    (bus.ch_n),
    .ext_trig_p_i   (bus.ext_p),
    .ext_trig_n_i   (bus.ext_n),
    .asg_trig_p_i   (bus.asg_p),
    .asg_trig_n_i   (bus.asg_n),
    .trig_o         (trig),
    .state_o        (state),
    .src_o          (src),
    .trig_cnt_o     (cnt)
  );

  always #5 clk = ~clk;

  assign obs = {trig, state, src, cnt};

  // Reference model: phase numbers follow the state_o encoding; holdoff is a
  // deadline in absolute cycles rather than a down-counter.
  int          m_phase;
  int          m_src;
  logic [31:0] m_cnt;
  bit          m_trig;
  longint      cyc = 0;
  longint      ready_at = 0;

  function automatic bit m_sel(input int code);
    if (code == 1) return bus.sw;
    if (code >= 2 && code < 2 + 2*NCH)
      return ((code - 2) % 2 == 0) ? bus.ch_p[(code-2)/2] : bus.ch_n[(code-2)/2];
    case (code - 2*NCH)
      2: return bus.ext_p;
      3: return bus.ext_n;
      4: return bus.asg_p;
      5: return bus.asg_n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_src = 0; m_cnt = '0; m_trig = 0;
  endtask

  task automatic model_edge();
    bit s;
    s = m_sel(m_src);
    cyc++;
    m_trig = 0;
    if (rst_do) begin
      m_phase = 0; m_src = 0;
    end else if (cfg_new) begin
      m_src = int'(cfg_src); m_cnt = '0; m_phase = (cfg_src == 0) ? 0 : 1;
    end else if (m_phase == 1) begin
      if (dly_do) begin
        m_phase = 0; m_src = 0;
      end else if (s) begin
        m_trig = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (!cfg_mode) begin
          m_phase = 3; m_src = 0;
        end else if (cfg_holdoff != 0) begin
          m_phase = 2; ready_at = cyc + longint'(cfg_holdoff);
        end
      end
    end else if (m_phase == 2) begin
      if (dly_do) begin
        m_phase = 0; m_src = 0;
      end else if (cyc >= ready_at) m_phase = 1;
    end else if (m_phase == 3) begin
      if (trig_dis_clr) m_phase = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    cfg_src = '0; cfg_new = 0; cfg_mode = 0; cfg_holdoff = '0;
    rst_do = 0; dly_do = 0; trig_dis_clr = 0;
    bus.sw = 0; bus.ch_p = '0; bus.ch_n = '0;
    bus.ext_p = 0; bus.ext_n = 0; bus.asg_p = 0; bus.asg_n = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 0;
    cfg_src = 4'd6; cfg_new = 1; bus.sw = 1; bus.ch_p = '1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 39'd0) begin
      bad++; $display("FAIL reset_hold: got %h want %h", obs, 39'd0);
    end
    clear_inputs();
    model_reset();
    @(negedge clk);
    rstn = 1;
    step();
    total++;
    if (obs !== 39'd0) begin
      bad++; $display("FAIL reset_release: got %h want %h", obs, 39'd0);
    end
  endtask

  task automatic test_single();
    clear_inputs();
    cfg_src = 4'd6; cfg_mode = 0; cfg_new = 1;
    step();
    cfg_new = 0;
    total++;
    if (obs !== {1'b0, 2'd1, 4'd6, 32'd0}) begin
      bad++; $display("FAIL single_arm: got %h want %h", obs, {1'b0, 2'd1, 4'd6, 32'd0});
    end
    bus.ch_p = 4'b0100;
    step();
    bus.ch_p = '0;
    total++;
    if (obs !== {1'b1, 2'd3, 4'd0, 32'd1}) begin
      bad++; $display("FAIL single_fire: got %h want %h", obs, {1'b1, 2'd3, 4'd0, 32'd1});
    end
    step();
    total++;
    if (obs !== {1'b0, 2'd3, 4'd0, 32'd1}) begin
      bad++; $display("FAIL single_pulse_len: got %h want %h", obs, {1'b0, 2'd3, 4'd0, 32'd1});
    end
    bus.ch_p = 4'b0100; bus.sw = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (obs !== {1'b0, 2'd3, 4'd0, 32'd1}) begin
        bad++; $display("FAIL single_done_ignores[%0d]: got %h want %h", i, obs, {1'b0, 2'd3, 4'd0, 32'd1});
      end
    end
    bus.ch_p = '0; bus.sw = 0; trig_dis_clr = 1;
    step();
    trig_dis_clr = 0;
    total++;
    if (obs !== {1'b0, 2'd0, 4'd0, 32'd1}) begin
      bad++; $display("FAIL single_dis_clr: got %h want %h", obs, {1'b0, 2'd0, 4'd0, 32'd1});
    end
  endtask

  task automatic test_holdoff();
    logic [38:0] exp;
    clear_inputs();
    cfg_src = 4'd10; cfg_mode = 1; cfg_holdoff = 32'd5; cfg_new = 1;
    step();
    cfg_new = 0;
    total++;
    if (obs !== {1'b0, 2'd1, 4'd10, 32'd0}) begin
      bad++; $display("FAIL hold_arm: got %h want %h", obs, {1'b0, 2'd1, 4'd10, 32'd0});
    end
    bus.ext_p = 1;
    for (int i = 1; i <= 30; i++) begin
      step();
      exp = {((i-1) % 6 == 0) ? 1'b1 : 1'b0,
             ((i-1) % 6 == 5) ? 2'd1 : 2'd2,
             4'd10, 32'((i-1)/6 + 1)};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL hold_cycle[%0d]: got %h want %h", i, obs, exp);
      end
    end
    dly_do = 1;
    step();
    dly_do = 0; bus.ext_p = 0;
    total++;
    if (obs !== {1'b0, 2'd0, 4'd0, 32'd5}) begin
      bad++; $display("FAIL hold_dly_do: got %h want %h", obs, {1'b0, 2'd0, 4'd0, 32'd5});
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    cfg_src = 4'd1; cfg_mode = 1; cfg_holdoff = '0; cfg_new = 1; bus.sw = 1;
    step();
    cfg_new = 0;
    total++;
    if (obs !== {1'b0, 2'd1, 4'd1, 32'd0}) begin
      bad++; $display("FAIL b2b_arm: got %h want %h", obs, {1'b0, 2'd1, 4'd1, 32'd0});
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if (obs !== {1'b1, 2'd1, 4'd1, 32'(i)}) begin
        bad++; $display("FAIL b2b_cycle[%0d]: got %h want %h", i, obs, {1'b1, 2'd1, 4'd1, 32'(i)});
      end
    end
    bus.sw = 0; cfg_src = 4'd0; cfg_new = 1;
    step();
    cfg_new = 0;
    total++;
    if (obs !== {1'b0, 2'd0, 4'd0, 32'd0}) begin
      bad++; $display("FAIL b2b_off: got %h want %h", obs, {1'b0, 2'd0, 4'd0, 32'd0});
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    cfg_src = 4'd1; cfg_mode = 1; cfg_new = 1;
    step();
    cfg_new = 0; bus.sw = 1;
    step();
    total++;
    if (obs !== {1'b1, 2'd1, 4'd1, 32'd1}) begin
      bad++; $display("FAIL prio_first_fire: got %h want %h", obs, {1'b1, 2'd1, 4'd1, 32'd1});
    end
    rst_do = 1; cfg_new = 1;
    step();
    rst_do = 0;
    total++;
    if (obs !== {1'b0, 2'd0, 4'd0, 32'd1}) begin
      bad++; $display("FAIL prio_rst_do: got %h want %h", obs, {1'b0, 2'd0, 4'd0, 32'd1});
    end
    step();
    cfg_new = 0;
    total++;
    if (obs !== {1'b0, 2'd1, 4'd1, 32'd0}) begin
      bad++; $display("FAIL prio_cfg_new: got %h want %h", obs, {1'b0, 2'd1, 4'd1, 32'd0});
    end
    step();
    total++;
    if (obs !== {1'b1, 2'd1, 4'd1, 32'd1}) begin
      bad++; $display("FAIL prio_after_arm: got %h want %h", obs, {1'b1, 2'd1, 4'd1, 32'd1});
    end
    bus.sw = 0; rst_do = 1;
    step();
    rst_do = 0;
  endtask

  task automatic test_invalid();
    logic [3:0] code;
    for (int c = 14; c <= 15; c++) begin
      clear_inputs();
      code = 4'(c);
      cfg_src = code; cfg_new = 1;
      step();
      cfg_new = 0;
      total++;
      if (obs !== {1'b0, 2'd1, code, 32'd0}) begin
        bad++; $display("FAIL invalid_arm[%0d]: got %h want %h", c, obs, {1'b0, 2'd1, code, 32'd0});
      end
      for (int i = 0; i < 10; i++) begin
        bus.sw = 1'($urandom); bus.ch_p = 4'($urandom); bus.ch_n = 4'($urandom);
        bus.ext_p = 1'($urandom); bus.ext_n = 1'($urandom);
        bus.asg_p = 1'($urandom); bus.asg_n = 1'($urandom);
        if (i == 0) begin
          bus.sw = 1; bus.ch_p = '1; bus.ch_n = '1;
          bus.ext_p = 1; bus.ext_n = 1; bus.asg_p = 1; bus.asg_n = 1;
        end
        cfg_mode = 1'($urandom); cfg_holdoff = 32'($urandom_range(0, 5));
        step();
        total++;
        if (obs !== {1'b0, 2'd1, code, 32'd0}) begin
          bad++; $display("FAIL invalid_quiet[%0d.%0d]: got %h want %h", c, i, obs, {1'b0, 2'd1, code, 32'd0});
        end
      end
      dly_do = 1;
      step();
      dly_do = 0;
      total++;
      if (obs !== {1'b0, 2'd0, 4'd0, 32'd0}) begin
        bad++; $display("FAIL invalid_dly_do[%0d]: got %h want %h", c, obs, {1'b0, 2'd0, 4'd0, 32'd0});
      end
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    cfg_src = 4'd10; cfg_mode = 1; cfg_holdoff = 32'd20; cfg_new = 1;
    step();
    cfg_new = 0; bus.ext_p = 1;
    step();
    total++;
    if (obs !== {1'b1, 2'd2, 4'd10, 32'd1}) begin
      bad++; $display("FAIL async_fire: got %h want %h", obs, {1'b1, 2'd2, 4'd10, 32'd1});
    end
    // Retuning mode/holdoff mid-holdoff must not shorten the running wait.
    cfg_holdoff = '0; cfg_mode = 0;
    repeat (3) step();
    total++;
    if (obs !== {1'b0, 2'd2, 4'd10, 32'd1}) begin
      bad++; $display("FAIL async_holdoff_kept: got %h want %h", obs, {1'b0, 2'd2, 4'd10, 32'd1});
    end
    #2 rstn = 0;
    #1;
    total++;
    if (obs !== 39'd0) begin
      bad++; $display("FAIL async_reset_now: got %h want %h", obs, 39'd0);
    end
    clear_inputs();
    model_reset();
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_random();
    logic [38:0] exp;
    for (int i = 0; i < 600; i++) begin
      rst_do       = ($urandom_range(0, 63) == 0);
      cfg_new      = ($urandom_range(0, 11) == 0);
      cfg_src      = 4'($urandom_range(0, 15));
      cfg_mode     = 1'($urandom);
      cfg_holdoff  = 32'($urandom_range(0, 6));
      dly_do       = ($urandom_range(0, 31) == 0);
      trig_dis_clr = ($urandom_range(0, 7) == 0);
      bus.sw = ($urandom_range(0, 3) == 0);
      bus.ch_p = 4'($urandom); bus.ch_n = 4'($urandom);
      bus.ext_p = 1'($urandom); bus.ext_n = 1'($urandom);
      bus.asg_p = 1'($urandom); bus.asg_n = 1'($urandom);
      step();
      exp = {m_trig, 2'(m_phase), 4'(m_src), m_cnt};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp);
      end
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_holdoff();
    test_back_to_back();
    test_priority();
    test_invalid();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
